// File: rtl/mux_pkg.sv
// Shared constants for the N-to-1 stream multiplexer family.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Select width for n channels, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 32; k++) begin
      if ((1 << r) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping past N-1 to 0.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt,
  output logic          gnt_vld
);

  logic [N-1:0]  rot;
  logic [SW-1:0] pe;
  logic [SW:0]   sum;

  always_comb begin
    // rot[i] = req[(ptr + i) mod N]
    rot = N'({req, req} >> ptr);
    pe  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pe = SW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, pe};
    if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
    gnt     = sum[SW-1:0];
    gnt_vld = |req;
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-to-1 W-bit stream mux with registered output; explicit-select or round-robin grant.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch
);

  localparam int NP = 1 << SW;

  logic [W-1:0]  ch_data [N];
  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_gnt;
  logic          rr_vld;
  logic [SW-1:0] gnt;
  logic          gnt_vld;
  logic          load_en;
  logic          sel_ok;
  logic          xfer;
  logic [NP-1:0] valid_pad;
  logic [NP-1:0] rdy_pad;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*W +: W];
  end

  rr_pick #(.N(N), .SW(SW)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_vld (rr_vld)
  );

  assign load_en = !out_valid || out_ready;
  assign sel_ok  = {1'b0, sel} < (SW+1)'(N);

  // Padding to a power of two keeps sel indexing in range for any N.
  always_comb begin
    valid_pad          = '0;
    valid_pad[N-1:0]   = in_valid;
    rdy_pad            = '0;
    gnt                = '0;
    gnt_vld            = 1'b0;
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
      if (rr_vld) rdy_pad[rr_gnt] = 1'b1;
    end else begin
      gnt     = sel;
      gnt_vld = sel_ok && valid_pad[sel];
      if (sel_ok) rdy_pad[sel] = 1'b1;
    end
    in_ready = (!rst && load_en) ? rdy_pad[N-1:0] : '0;
    xfer     = !rst && load_en && gnt_vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt];
        out_ch    <= gnt;
        if (mode == MODE_RR) ptr <= (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Scoreboard bench: arithmetic reference model pushes expected beats, a monitor pops and compares.
module tb_mux_nto1_stream;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;
  localparam int N6  = 6;
  localparam int SW6 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;

  logic            mode6;
  logic [SW6-1:0]  sel6;
  logic [N6-1:0]   in_valid6;
  logic [N6-1:0]   in_ready6;
  logic [N6*W-1:0] in_data6;
  logic            out_valid6;
  logic            out_ready6;
  logic [W-1:0]    out_data6;
  logic [SW6-1:0]  out_ch6;

  mux_nto1_stream #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  mux_nto1_stream #(.N(N6), .W(W)) dut6 (
    .clk(clk), .rst(rst), .mode(mode6), .sel(sel6),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .out_ch(out_ch6)
  );

  typedef struct {
    logic [W-1:0] d;
    int           ch;
  } beat_t;

  beat_t        q[$];
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  int           m_ptr = 0;
  bit           m_valid = 1'b0;
  logic [N-1:0] m_acc = '0;

  int           g;
  bit           gv;
  bit           load;
  logic [N-1:0] exp_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the beat presented now must be the oldest expected beat.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(q[0].d));
        chk("out_ch", 64'(out_ch), 64'(q[0].ch));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Reference model: decides the grant from the rules and predicts the next beat.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (rst) begin
        chk("in_ready_rst", 64'(in_ready), 64'd0);
        q.delete();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_acc   = '0;
      end else begin
        load    = !m_valid || out_ready;
        gv      = 1'b0;
        g       = 0;
        exp_rdy = '0;
        if (mode) begin
          for (int k = 0; k < N; k++) begin
            if (!gv && in_valid[(m_ptr + k) % N]) begin
              gv = 1'b1;
              g  = (m_ptr + k) % N;
            end
          end
          if (gv && load) exp_rdy[g] = 1'b1;
        end else begin
          g  = int'(sel);
          gv = in_valid[g];
          if (load) exp_rdy[g] = 1'b1;
        end
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        m_acc = '0;
        if (gv && load) begin
          q.push_back('{d: in_data[g*W +: W], ch: g});
          m_acc[g] = 1'b1;
          if (mode) m_ptr = (g + 1) % N;
        end
        m_valid = (gv && load) || (m_valid && !out_ready);
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '1; in_data = 32'hD3C2B1A0; out_ready = 1'b1;
    mode6 = 1'b0; sel6 = '0; in_valid6 = '1; out_ready6 = 1'b1;
    in_data6 = {8'h65, 8'h64, 8'h63, 8'h62, 8'h61, 8'h60};

    // Reset with every producer asserting valid.
    step();
    mon_en = 1'b1;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = '0;
    rst = 1'b0;

    // Six-channel instance: out-of-range select never grants.
    sel6 = 3'd6;
    #1 chk("n6_sel6_ready", 64'(in_ready6), 64'd0);
    step();
    chk("n6_sel6_valid", 64'(out_valid6), 64'd0);
    sel6 = 3'd5;
    #1 chk("n6_sel5_ready", 64'(in_ready6), 64'h20);
    step();
    chk("n6_sel5_valid", 64'(out_valid6), 64'd1);
    chk("n6_sel5_data", 64'(out_data6), 64'h65);
    chk("n6_sel5_ch", 64'(out_ch6), 64'd5);
    sel6 = 3'd7;
    #1 chk("n6_sel7_ready", 64'(in_ready6), 64'd0);
    step();
    chk("n6_sel7_valid", 64'(out_valid6), 64'd0);

    // Explicit select walks the channels.
    in_valid = '1;
    for (int k = 0; k < N; k++) begin
      sel = SW'(k);
      step();
      chk("sel_data", 64'(out_data), 64'(8'hA0 + 8'h11 * k));
      chk("sel_ch", 64'(out_ch), 64'(k));
    end

    // Round-robin from ptr 0, wrapping 3 -> 0.
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_ch", 64'(out_ch), 64'(k % N));
    end
    step();
    chk("rr_ptr3_setup", 64'(out_ch), 64'd2);
    in_valid = 4'b0100;
    step();
    chk("rr_wrap_ch2", 64'(out_ch), 64'd2);
    in_valid = 4'b1001;
    step();
    chk("rr_ch3_first", 64'(out_ch), 64'd3);

    // Backpressure holds the beat and blocks every input.
    in_valid = 4'b0010;
    step();
    chk("bp_load_ch", 64'(out_ch), 64'd1);
    out_ready = 1'b0;
    in_valid  = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_ch", 64'(out_ch), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'hB1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'b0100);
    step();
    chk("bp_no_bubble_valid", 64'(out_valid), 64'd1);
    chk("bp_no_bubble_ch", 64'(out_ch), 64'd2);

    // Reset during a stall drops the beat and rewinds the pointer.
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_stall_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rst_ptr_zero", 64'(out_ch), 64'd0);

    // Randomised traffic; producers hold valid/data until accepted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(in_valid[i] && !m_acc[i])) begin
          in_valid[i] = ($urandom_range(0, 99) < 55);
          in_data[i*W +: W] = W'($urandom);
        end
      end
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      sel       = SW'($urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 99) < 70);
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end

    rst = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
